// File: rtl/pyrm_dcache_arbiter_if.sv
// pyrm_dcache_arbiter_if: wb/dbg request-response channels plus the data-cache port, bundled for the arbiter
interface pyrm_dcache_arbiter_if #(parameter int LINE_W = 11, parameter int DATA_W = 64);
  logic              wb_req_valid_pyri, wb_req_retry_pyro, wb_req_we_pyri, wb_req_unsigned_pyri;
  logic [63:0]       wb_req_addr_pyri;
  logic [1:0]        wb_req_size_pyri;
  logic [DATA_W-1:0] wb_req_wdata_pyri, wb_resp_data_pyro;
  logic              wb_resp_valid_pyro, wb_resp_retry_pyri;
  logic              dbg_req_valid_pyri, dbg_req_retry_pyro, dbg_req_we_pyri, dbg_req_unsigned_pyri;
  logic [63:0]       dbg_req_addr_pyri;
  logic [1:0]        dbg_req_size_pyri;
  logic [DATA_W-1:0] dbg_req_wdata_pyri, dbg_resp_data_pyro;
  logic              dbg_resp_valid_pyro, dbg_resp_retry_pyri;
  logic [LINE_W-1:0] dc_addr_pyro;
  logic              dc_write_pyro;
  logic [DATA_W-1:0] dc_wdata1_pyro, dc_wdata2_pyro, dc_rdata1_pyri, dc_rdata2_pyri;
  modport slave (
    input  wb_req_valid_pyri, wb_req_we_pyri, wb_req_addr_pyri, wb_req_size_pyri, wb_req_unsigned_pyri,
    input  wb_req_wdata_pyri, wb_resp_retry_pyri,
    output wb_req_retry_pyro, wb_resp_valid_pyro, wb_resp_data_pyro,
    input  dbg_req_valid_pyri, dbg_req_we_pyri, dbg_req_addr_pyri, dbg_req_size_pyri, dbg_req_unsigned_pyri,
    input  dbg_req_wdata_pyri, dbg_resp_retry_pyri,
    output dbg_req_retry_pyro, dbg_resp_valid_pyro, dbg_resp_data_pyro,
    output dc_addr_pyro, dc_write_pyro, dc_wdata1_pyro, dc_wdata2_pyro,
    input  dc_rdata1_pyri, dc_rdata2_pyri
  );
  modport master (
    output wb_req_valid_pyri, wb_req_we_pyri, wb_req_addr_pyri, wb_req_size_pyri, wb_req_unsigned_pyri,
    output wb_req_wdata_pyri, wb_resp_retry_pyri,
    input  wb_req_retry_pyro, wb_resp_valid_pyro, wb_resp_data_pyro,
    output dbg_req_valid_pyri, dbg_req_we_pyri, dbg_req_addr_pyri, dbg_req_size_pyri, dbg_req_unsigned_pyri,
    output dbg_req_wdata_pyri, dbg_resp_retry_pyri,
    input  dbg_req_retry_pyro, dbg_resp_valid_pyro, dbg_resp_data_pyro,
    input  dc_addr_pyro, dc_write_pyro, dc_wdata1_pyro, dc_wdata2_pyro,
    output dc_rdata1_pyri, dc_rdata2_pyri
  );
endinterface

// File: rtl/pyrm_dcache_arbiter.sv
// pyrm_dcache_arbiter: wb/dbg arbiter and read / read-modify-write sequencer for a dual-line data cache
// Define PYRM_DCACHE_ARB_RR_EN for round-robin arbitration; otherwise wb has fixed priority.
module pyrm_dcache_arbiter #(parameter int LINE_W = 11, parameter int DATA_W = 64) (
  input logic clk,
  input logic reset_n_pyri,
  pyrm_dcache_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;
  state_t state;
  logic id, we, uns, wr, rv_wb, rv_dbg, gnt_wb, gnt_dbg, go, sign;
  logic [LINE_W-1:0] idx;
  logic [2:0] off;
  logic [1:0] sz;
  logic [5:0] amt;
  logic [DATA_W-1:0] wdata, wd1, wd2, rdata, szm, lo, ld;
  logic [2*DATA_W-1:0] cat, bm, wsh, merged, sh;
`ifdef PYRM_DCACHE_ARB_RR_EN
  logic rr;
  assign gnt_wb = bus.wb_req_valid_pyri && (!bus.dbg_req_valid_pyri || !rr);
`else
  assign gnt_wb = bus.wb_req_valid_pyri;
`endif
  assign gnt_dbg = bus.dbg_req_valid_pyri && !gnt_wb;
  // Merge and extraction operate on the live read data during READ, so results are registered at that edge
  always_comb begin
    amt = {off, 3'b000};
    szm = sz == 2'd3 ? '1 : (64'd1 << (6'd8 << sz)) - 64'd1;
    cat = {bus.dc_rdata2_pyri, bus.dc_rdata1_pyri};
    bm = {{DATA_W{1'b0}}, szm} << amt;
    wsh = {{DATA_W{1'b0}}, wdata} << amt;
    merged = (cat & ~bm) | (wsh & bm);
    sh = cat >> amt;
    lo = sh[DATA_W-1:0] & szm;
    sign = |(lo & (szm ^ (szm >> 1)));
    ld = lo | ({DATA_W{sign & !uns}} & ~szm);
    go = id ? !bus.dbg_resp_retry_pyri : !bus.wb_resp_retry_pyri;
  end
  assign bus.wb_req_retry_pyro = !(reset_n_pyri && state == IDLE && gnt_wb);
  assign bus.dbg_req_retry_pyro = !(reset_n_pyri && state == IDLE && gnt_dbg);
  assign bus.wb_resp_valid_pyro = rv_wb;
  assign bus.dbg_resp_valid_pyro = rv_dbg;
  assign bus.wb_resp_data_pyro = rdata;
  assign bus.dbg_resp_data_pyro = rdata;
  assign bus.dc_addr_pyro = idx;
  assign bus.dc_write_pyro = wr && reset_n_pyri;
  assign bus.dc_wdata1_pyro = wd1;
  assign bus.dc_wdata2_pyro = wd2;
  always_ff @(posedge clk) begin
    if (!reset_n_pyri) begin
      state <= IDLE;
      {id, we, uns, wr, rv_wb, rv_dbg} <= '0;
      idx <= '0;
      off <= '0;
      sz <= '0;
      wdata <= '0;
      wd1 <= '0;
      wd2 <= '0;
      rdata <= '0;
`ifdef PYRM_DCACHE_ARB_RR_EN
      rr <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (gnt_wb || gnt_dbg) begin
          id <= gnt_dbg;
          we <= gnt_dbg ? bus.dbg_req_we_pyri : bus.wb_req_we_pyri;
          idx <= gnt_dbg ? bus.dbg_req_addr_pyri[LINE_W+2:3] : bus.wb_req_addr_pyri[LINE_W+2:3];
          off <= gnt_dbg ? bus.dbg_req_addr_pyri[2:0] : bus.wb_req_addr_pyri[2:0];
          sz <= gnt_dbg ? bus.dbg_req_size_pyri : bus.wb_req_size_pyri;
          uns <= gnt_dbg ? bus.dbg_req_unsigned_pyri : bus.wb_req_unsigned_pyri;
          wdata <= gnt_dbg ? bus.dbg_req_wdata_pyri : bus.wb_req_wdata_pyri;
`ifdef PYRM_DCACHE_ARB_RR_EN
          rr <= gnt_wb;
`endif
          state <= READ;
        end
        READ: begin
          wd1 <= merged[DATA_W-1:0];
          wd2 <= merged[2*DATA_W-1:DATA_W];
          rdata <= we ? '0 : ld;
          wr <= we;
          {rv_dbg, rv_wb} <= we ? 2'b00 : {id, !id};
          state <= we ? WRITE : RESP;
        end
        WRITE: begin
          wr <= 1'b0;
          {rv_dbg, rv_wb} <= {id, !id};
          state <= RESP;
        end
        default: if (go) begin
          {rv_dbg, rv_wb} <= 2'b00;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_pyrm_dcache_arbiter.sv
// tb_pyrm_dcache_arbiter: directed vectors against a behavioural dual-line cache model
module tb_pyrm_dcache_arbiter;
  logic clk = 1'b0, rst_n = 1'b0;
  int nvec = 0, nmis = 0;
  logic [63:0] mem [2048];
  logic [63:0] w1, w2, hold;
  logic [10:0] a2;
  int g [16];
  int ng;
  pyrm_dcache_arbiter_if b();
  pyrm_dcache_arbiter dut (.clk(clk), .reset_n_pyri(rst_n), .bus(b));
  always #5 clk = ~clk;
  assign a2 = b.dc_addr_pyro + 11'd1;
  assign b.dc_rdata1_pyri = mem[b.dc_addr_pyro];
  assign b.dc_rdata2_pyri = mem[a2];
  initial for (int i = 0; i < 2048; i++) mem[i] <= '0;
  always @(posedge clk) if (b.dc_write_pyro) begin
    mem[b.dc_addr_pyro] <= b.dc_wdata1_pyro;
    mem[a2] <= b.dc_wdata2_pyro;
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    if (obs !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic logic rtry(input bit p);
    return p ? b.dbg_req_retry_pyro : b.wb_req_retry_pyro;
  endfunction
  function automatic logic rv(input bit p);
    return p ? b.dbg_resp_valid_pyro : b.wb_resp_valid_pyro;
  endfunction
  function automatic logic [63:0] rd(input bit p);
    return p ? b.dbg_resp_data_pyro : b.wb_resp_data_pyro;
  endfunction
  task automatic drive(input bit p, input bit v, input bit we, input logic [63:0] a, input logic [1:0] sz,
                       input bit u, input logic [63:0] wd);
    if (!p) begin
      b.wb_req_valid_pyri = v; b.wb_req_we_pyri = we; b.wb_req_addr_pyri = a;
      b.wb_req_size_pyri = sz; b.wb_req_unsigned_pyri = u; b.wb_req_wdata_pyri = wd;
    end else begin
      b.dbg_req_valid_pyri = v; b.dbg_req_we_pyri = we; b.dbg_req_addr_pyri = a;
      b.dbg_req_size_pyri = sz; b.dbg_req_unsigned_pyri = u; b.dbg_req_wdata_pyri = wd;
    end
  endtask
  task automatic setv(input bit p, input bit v);
    if (!p) b.wb_req_valid_pyri = v;
    else b.dbg_req_valid_pyri = v;
  endtask
  task automatic wait_grant(input string tag, input bit p);
    int n = 0;
    do begin @(negedge clk); n++; end while (rtry(p) && n < 20);
    chk({tag, " grant"}, 64'(rtry(p)), 64'd0);
  endtask
  task automatic do_op(input string tag, input bit p, input bit we, input logic [63:0] a, input logic [1:0] sz,
                       input bit u, input logic [63:0] wd, input logic [63:0] exp);
    int lat = 0, wrs = 0;
    logic [10:0] ad = '0;
    drive(p, 1'b1, we, a, sz, u, wd);
    wait_grant(tag, p);
    @(posedge clk); #1;
    setv(p, 1'b0);
    do begin
      @(negedge clk); lat++;
      if (lat == 1) ad = b.dc_addr_pyro;
      if (b.dc_write_pyro) begin wrs++; w1 = b.dc_wdata1_pyro; w2 = b.dc_wdata2_pyro; end
    end while (!rv(p) && lat < 8);
    chk({tag, " addr"}, 64'(ad), 64'(a[13:3]));
    chk({tag, " latency"}, 64'(lat), we ? 64'd3 : 64'd2);
    chk({tag, " writes"}, 64'(wrs), 64'(we));
    chk({tag, " data"}, rd(p), exp);
    @(posedge clk); #1;
  endtask
  initial begin
    b.wb_resp_retry_pyri = 1'b0; b.dbg_resp_retry_pyri = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 64'h0, 2'd3, 1'b0, 64'h0);
    drive(1'b1, 1'b1, 1'b0, 64'h8, 2'd3, 1'b1, 64'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst wb retry", 64'(b.wb_req_retry_pyro), 64'd1);
    chk("rst dbg retry", 64'(b.dbg_req_retry_pyro), 64'd1);
    chk("rst write", 64'(b.dc_write_pyro), 64'd0);
    chk("rst resp", 64'({b.wb_resp_valid_pyro, b.dbg_resp_valid_pyro}), 64'd0);
    chk("rst addr", 64'(b.dc_addr_pyro), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    ng = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("excl grant", 64'(!b.wb_req_retry_pyro && !b.dbg_req_retry_pyro), 64'd0);
      if (!b.wb_req_retry_pyro && ng < 16) begin g[ng] = 0; ng++; end
      if (!b.dbg_req_retry_pyro && ng < 16) begin g[ng] = 1; ng++; end
    end
    @(posedge clk); #1;
    setv(1'b0, 1'b0); setv(1'b1, 1'b0);
    chk("contend count", 64'(ng >= 4), 64'd1);
    for (int i = 0; i < 4; i++)
`ifdef PYRM_DCACHE_ARB_RR_EN
      chk($sformatf("contend grant%0d", i), 64'(g[i]), 64'(i % 2));
`else
      chk($sformatf("contend grant%0d", i), 64'(g[i]), 64'd0);
`endif
    repeat (4) @(posedge clk); #1;
    do_op("st d 0x40", 1'b0, 1'b1, 64'h40, 2'd3, 1'b0, 64'h1122334455667788, 64'h0);
    chk("st d 0x40 wdata1", w1, 64'h1122334455667788);
    chk("st d 0x40 wdata2", w2, 64'h0);
    do_op("ld d 0x40", 1'b0, 1'b0, 64'h40, 2'd3, 1'b0, 64'h0, 64'h1122334455667788);
    do_op("st w 0x7e", 1'b1, 1'b1, 64'h7E, 2'd2, 1'b0, 64'hAABBCCDD, 64'h0);
    chk("st w 0x7e wdata1", w1, 64'hCCDD000000000000);
    chk("st w 0x7e wdata2", w2, 64'h000000000000AABB);
    do_op("ld ws 0x7e", 1'b1, 1'b0, 64'h7E, 2'd2, 1'b0, 64'h0, 64'hFFFFFFFFAABBCCDD);
    do_op("ld wu 0x7e", 1'b0, 1'b0, 64'h7E, 2'd2, 1'b1, 64'h0, 64'h00000000AABBCCDD);
    do_op("ld bs 0x47", 1'b1, 1'b0, 64'h47, 2'd0, 1'b0, 64'h0, 64'h11);
    do_op("ld bs 0x7f", 1'b0, 1'b0, 64'h7F, 2'd0, 1'b0, 64'h0, 64'hFFFFFFFFFFFFFFCC);
    do_op("ld hu 0x7f", 1'b1, 1'b0, 64'h7F, 2'd1, 1'b1, 64'h0, 64'h000000000000BBCC);
    do_op("ld hs 0x44", 1'b0, 1'b0, 64'h44, 2'd1, 1'b0, 64'h0, 64'h3344);
    do_op("st d 0x3fff", 1'b0, 1'b1, 64'h3FFF, 2'd3, 1'b0, 64'h0102030405060708, 64'h0);
    chk("st d 0x3fff wdata1", w1, 64'h0800000000000000);
    chk("st d 0x3fff wdata2", w2, 64'h0001020304050607);
    do_op("ld d 0x3fff", 1'b1, 1'b0, 64'hFFFF000000003FFF, 2'd3, 1'b0, 64'h0, 64'h0102030405060708);
    b.wb_resp_retry_pyri = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 64'h40, 2'd3, 1'b0, 64'h0);
    wait_grant("bp wb", 1'b0);
    @(posedge clk); #1;
    setv(1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 64'h7E, 2'd2, 1'b0, 64'h0);
    @(negedge clk);
    @(negedge clk);
    hold = b.wb_resp_data_pyro;
    chk("bp data", hold, 64'h1122334455667788);
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge clk);
      chk("bp valid held", 64'(b.wb_resp_valid_pyro), 64'd1);
      chk("bp data held", b.wb_resp_data_pyro, 64'h1122334455667788);
      chk("bp dbg stalled", 64'(b.dbg_req_retry_pyro), 64'd1);
    end
    @(posedge clk); #1 b.wb_resp_retry_pyri = 1'b0;
    @(negedge clk);
    chk("bp dbg stalled last", 64'(b.dbg_req_retry_pyro), 64'd1);
    @(negedge clk);
    chk("bp dbg granted", 64'(b.dbg_req_retry_pyro), 64'd0);
    chk("bp wb resp done", 64'(b.wb_resp_valid_pyro), 64'd0);
    @(posedge clk); #1;
    setv(1'b1, 1'b0);
    repeat (2) @(negedge clk);
    chk("bp dbg resp", 64'(b.dbg_resp_valid_pyro), 64'd1);
    chk("bp dbg data", b.dbg_resp_data_pyro, 64'hFFFFFFFFAABBCCDD);
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, 1'b1, 1'b1, 64'h40, 2'd3, 1'b0, 64'hDEADBEEFCAFEF00D);
      wait_grant($sformatf("rst st%0d", k), 1'b0);
      @(posedge clk); #1;
      setv(1'b0, 1'b0);
      if (k == 1) begin @(posedge clk); #1; end
      rst_n = 1'b0;
      @(negedge clk);
      chk($sformatf("rst st%0d write gated", k), 64'(b.dc_write_pyro), 64'd0);
      @(negedge clk);
      chk($sformatf("rst st%0d addr", k), 64'(b.dc_addr_pyro), 64'd0);
      @(posedge clk); #1 rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        chk($sformatf("rst st%0d quiet", k), 64'({b.dc_write_pyro, b.wb_resp_valid_pyro}), 64'd0);
      end
      @(posedge clk); #1;
      do_op($sformatf("rst st%0d reload", k), 1'b0, 1'b0, 64'h40, 2'd3, 1'b0, 64'h0, 64'h1122334455667788);
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule

// File: doc/pyrm_dcache_arbiter.md
# pyrm_dcache_arbiter

Sequencing controller and two-port arbiter for the single-ported data cache (2048 lines × 64 bits, dual-line read at `addr` and `addr+1`, synchronous write). It serves the write-back stage (`wb`) and the debug port (`dbg`). Requests arrive on valid/retry channels. The block:
- grants one requester at a time;
- runs the cache read / read-modify-write sequence, including accesses that straddle two lines;
- returns aligned, extended load data on a per-requester response channel.

## Interface
- `LINE_W`, 11: cache line-index width.
- `DATA_W`, 64: data and line width; fixed at 64.
- `clk` in 1: sole clock; all state on rising edge.
- `reset_n_pyri` in 1: synchronous, active-low reset.
- `wb_req_valid_pyri` in 1: write-back request valid.
- `wb_req_retry_pyro` out 1: write-back request stalled.
- `wb_req_we_pyri` in 1: 1 = store, 0 = load.
- `wb_req_addr_pyri` in 64: byte address; bits [13:3] are the line index, bits [2:0] the byte offset, remaining bits ignored.
- `wb_req_size_pyri` in 2: 0 = byte, 1 = half, 2 = word, 3 = double.
- `wb_req_unsigned_pyri` in 1: load zero-extends when 1, sign-extends when 0.
- `wb_req_wdata_pyri` in 64: store data, right-aligned.
- `wb_resp_valid_pyro` out 1: response valid.
- `wb_resp_retry_pyri` in 1: response stalled.
- `wb_resp_data_pyro` out 64: load result; 0 for stores.
- `dbg_*`: identical set to `wb_*`, for the debug requester.
- `dc_addr_pyro` out 11: cache line index.
- `dc_write_pyro` out 1: cache write enable.
- `dc_wdata1_pyro` out 64: write data for line `addr`.
- `dc_wdata2_pyro` out 64: write data for line `addr+1`.
- `dc_rdata1_pyri` in 64: combinational read of line `addr`.
- `dc_rdata2_pyri` in 64: combinational read of line `addr+1`.

## Operation
- Handshake rule: a transfer occurs on a cycle with `valid=1` and `retry=0`. Once a sender raises `valid`, it holds `valid` and its payload stable until the transfer.
- FSM states: IDLE, READ, WRITE, RESP.
- IDLE:
  - Arbitrates among valid requests, grants one, and latches its payload and requester id.
  - Asserts `_req_retry_pyro=0` only for the granted port; every other port sees `retry=1`.
  - Next state is READ.
- READ:
  - `dc_addr_pyro` = latched `addr[13:3]`; `dc_rdata1_pyri` and `dc_rdata2_pyri` are captured into `line1` and `line2`.
  - Next state is WRITE if the request is a store, otherwise RESP.
- WRITE:
  - Bytes `off .. off+(1<<size)-1` of the concatenation {`line2`,`line1`} are replaced with the low bytes of `wdata`; all other bytes keep their captured values.
  - Drives `dc_write_pyro=1` and both merged lines for exactly one cycle, then goes to RESP.
- RESP:
  - The granted port sees `resp_valid=1`.
  - Load data: {`line2`,`line1`} is shifted right by `8*off`, masked to the access size, then sign- or zero-extended per `unsigned`. A double access is passed through unmasked.
  - Store data: 0.
  - Returns to IDLE on the response transfer.
- Arbitration:
  - Round-robin between `wb` and `dbg`; the pointer flips to the non-granted port after each grant.
  - A sole valid requester always wins.
- Outputs outside their active states:
  - `dc_write_pyro` is 0 outside WRITE.
  - `dc_addr_pyro` holds the last latched index.
  - `resp_valid` is 0 outside RESP.
  - Both `req_retry` outputs are 1 outside IDLE.
- Boundary conditions:
  - An access with `off+(1<<size) > 8` spans both lines; both lines are written on a store.
  - Line index 2047: `addr+1` wrap is handled by the cache, with no special case here.
  - Requests arriving while the block is busy are stalled by retry and never dropped.
  - Simultaneous valid requests in IDLE are resolved by the round-robin pointer.

## Timing
- Reset, sampled with `reset_n_pyri=0` at a clock edge, sets:
  - state to IDLE, with round-robin priority initialized to `wb`;
  - latched payload cleared to 0, so `dc_addr_pyro=0`;
  - `dc_write_pyro=0`, both `resp_valid=0`, both `req_retry=1`.
- While `reset_n_pyri=0`, `dc_write_pyro` is forced to 0 combinationally, so no cache write can occur in a reset cycle.
- Reset mid-sequence aborts the operation: the pending response is discarded and a partially sequenced store is not written.
- Load latency: accepted at cycle T, READ at T+1, `resp_valid` at T+2.
- Store latency: accepted at T, READ at T+1, write at T+2, `resp_valid` at T+3.
- Under `resp_retry=1`, RESP holds its outputs stable. Throughput is one request per 3 cycles (load) or 4 cycles (store) with no retry stall.

## Configuration
- `PYRM_DCACHE_ARB_RR_EN` defined: round-robin arbitration as described above.
- `PYRM_DCACHE_ARB_RR_EN` undefined: fixed priority, with `wb` always winning simultaneous requests. The round-robin pointer is not built, and `dbg` is granted only in cycles where `wb_req_valid_pyri=0`.

## Test plan
- Reset: hold `reset_n_pyri=0` 2 cycles with both requests valid -> both `req_retry=1`, `dc_write_pyro=0`, both `resp_valid=0`, `dc_addr_pyro=0`.
- Aligned double: `wb` stores 0x1122334455667788 at 0x40, then loads double at 0x40 -> `dc_addr_pyro=8`, one write pulse 2 cycles after store accept, load response 0x1122334455667788 exactly 2 cycles after accept.
- Straddling store: `dbg` stores word 0xAABBCCDD at 0x7E on zeroed lines 15/16 -> `dc_wdata1_pyro`=0xCCDD000000000000 and `dc_wdata2_pyro`=0x000000000000AABB. A signed word load at 0x7E returns 0xFFFFFFFFAABBCCDD; with `unsigned=1` it returns 0x00000000AABBCCDD.
- Contention: both ports issue loads every cycle -> grants alternate wb, dbg, wb, … with RR_EN defined; only `wb` is granted with it undefined.
- Response backpressure: hold `wb_resp_retry_pyri=1` for 5 cycles -> `resp_valid` and data stable, a `dbg` request stays at `retry=1`, and is granted the cycle after retry drops.
- Reset mid-store: deassert `reset_n_pyri` in READ of a store -> no `dc_write_pyro` pulse, no response, IDLE after reset release.
